// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory-side responder of the multicycle RISC-V core.
//   mr_state_t  : responder control states
//   WORD_BYTES  : bytes per storage word
//   CNT_W       : width of the wait-state counter (WAIT_CYCLES range 0..15)
//   addr_fault  : 1 when a byte address is misaligned or beyond the stored words
package rv_mem_pkg;

   typedef enum logic [1:0] {
      MR_IDLE,
      MR_WAIT,
      MR_RESP
   } mr_state_t;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned CNT_W      = 4;

   function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr & 32'(WORD_BYTES - 1)) != '0;
      out_of_range = {2'b00, addr[31:2]} >= depth;
      return misaligned || out_of_range;
   endfunction

endpackage

// File: rtl/rv_mem_array.sv
// Word storage for rv_mem_responder: synchronous RAM, one write and one read index,
// registered read data (one cycle latency). Contents are not reset.
//   clk   in   clock
//   we    in   write enable for word widx
//   widx  in   write word index
//   wdata in   write data
//   ridx  in   read word index, sampled every clock
//   rdata out  word at ridx as of the previous clock edge
module rv_mem_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] widx,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] ridx,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[widx] <= wdata;
      end
      rdata <= mem_q[ridx];
   end

endmodule

// File: rtl/rv_mem_responder.sv
// Memory-side responder for the multicycle RISC-V core. Accepts one word fetch/load/store
// at a time, waits WAIT_CYCLES cycles, then answers with a one-cycle ready pulse.
// Misaligned or out-of-range accesses complete with err=1, rdata=0 and no write.
//   clk   in   clock
//   rst   in   asynchronous active-high reset
//   req   in   request valid, held with we/addr/wdata until ready
//   we    in   1 = store, 0 = fetch/load
//   addr  in   byte address (word index = addr[31:2])
//   wdata in   store data
//   rdata out  read data, valid in the ready cycle of a read, else 0
//   ready out  one-cycle completion pulse
//   err   out  access fault, only together with ready
module rv_mem_responder
   import rv_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

   mr_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             we_q, we_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             fault_q, fault_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic             rdv_q, rdv_d;

   logic             mem_we;
   logic [AW-1:0]    mem_ridx;
   logic [31:0]      mem_rdata;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      fault_d = fault_q;

      case (state_q)
         MR_IDLE: begin
            if (req) begin
               idx_d   = addr[AW+1:2];
               we_d    = we;
               wdata_d = wdata;
               fault_d = addr_fault(addr, DEPTH_WORDS);
               cnt_d   = WAIT_LD;
               state_d = (WAIT_CYCLES == 0) ? MR_RESP : MR_WAIT;
            end
         end
         MR_WAIT: begin
            if (!req) begin
               state_d = MR_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = MR_RESP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         MR_RESP: begin
            // The response completes even if req has already dropped.
            state_d = MR_IDLE;
         end
         default: begin
            state_d = MR_IDLE;
         end
      endcase

      // Outputs are registered: they are decided from the next state and the
      // transaction attributes that will be latched alongside it.
      ready_d = (state_d == MR_RESP);
      err_d   = ready_d && fault_d;
      rdv_d   = ready_d && !we_d && !fault_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= MR_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         fault_q <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         fault_q <= fault_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         rdv_q   <= rdv_d;
      end
   end

   // The RAM read must be issued in the cycle before RESP. With no wait states
   // that cycle is the accepting IDLE cycle, before the latch holds the address.
   assign mem_ridx = (state_q == MR_IDLE) ? addr[AW+1:2] : idx_q;
   // Store commits on the edge that ends RESP; a reset clears state_q first, so
   // an interrupted store never writes.
   assign mem_we   = (state_q == MR_RESP) && we_q && !fault_q;

   rv_mem_array #(
      .DEPTH (DEPTH_WORDS),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .widx  (idx_q),
      .wdata (wdata_q),
      .ridx  (mem_ridx),
      .rdata (mem_rdata)
   );

   assign rdata = rdv_q ? mem_rdata : '0;
   assign ready = ready_q;
   assign err   = err_q;

endmodule

// File: tb/tb_rv_mem_responder.sv
// Self-checking bench for rv_mem_responder. Two instances: index 0 with no wait
// states, index 1 with two. A word-array reference model per instance predicts
// latency, err and read data for directed and randomized transactions.
module tb_rv_mem_responder;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        ready [2];
   logic        err   [2];

   logic [31:0] mdl [2][DEPTH];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
      .rdata(rdata[0]), .ready(ready[0]), .err(err[0]));

   rv_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
      .rdata(rdata[1]), .ready(ready[1]), .err(err[1]));

   function automatic int wait_of(input int sel);
      return (sel == 0) ? 0 : 2;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete transaction; when tog is set, addr/wdata are disturbed after acceptance.
   task automatic txn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit tog, output int lat, output logic [31:0] rd, output logic er);
      bit seen;
      seen = 0;
      lat  = -1;
      rd   = '0;
      er   = 1'b0;
      @(posedge clk); #1;
      req[sel] = 1'b1; we[sel] = w; addr[sel] = a; wdata[sel] = d;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (ready[sel]) begin
            seen = 1;
            lat  = k;
            rd   = rdata[sel];
            er   = err[sel];
         end else if (tog && k >= 1) begin
            addr[sel]  = a ^ 32'h4;
            wdata[sel] = ~d;
         end
      end
      req[sel] = 1'b0;
      @(negedge clk);
      check_eq($sformatf("bubble s%0d a%h", sel, a), 32'(ready[sel]), 32'd0);
   endtask

   task automatic mtxn(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input bit tog);
      int          lat;
      logic [31:0] rd;
      logic        er;
      bit          f;
      int unsigned wi;
      txn(sel, w, a, d, tog, lat, rd, er);
      f  = (a % 4 != 0) || (a / 4 >= DEPTH);
      wi = a / 4;
      check_eq($sformatf("latency s%0d a%h", sel, a), 32'(lat), 32'(wait_of(sel) + 1));
      check_eq($sformatf("err s%0d a%h", sel, a), 32'(er), 32'(f));
      if (!w) begin
         if (f) check_eq($sformatf("rdata fault s%0d a%h", sel, a), rd, 32'd0);
         else   check_eq($sformatf("rdata s%0d a%h", sel, a), rd, mdl[sel][wi]);
      end
      if (w && !f) mdl[sel][wi] = d;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        rv  [6];
      logic [31:0] rdv [6];
      bit          first;
      int          hits;
      bit          seen;

      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         check_eq($sformatf("reset ready s%0d", s), 32'(ready[s]), 32'd0);
         check_eq($sformatf("reset err s%0d", s), 32'(err[s]), 32'd0);
         check_eq($sformatf("reset rdata s%0d", s), rdata[s], 32'd0);
      end
      rst = 1'b0;

      // Basic store/read with two wait states.
      mtxn(1, 1'b1, 32'h10, 32'hDEADBEEF, 0);
      mtxn(1, 1'b0, 32'h10, 32'h0, 0);

      // Faults: misaligned read, out-of-range store must not alias onto word 0.
      mtxn(1, 1'b1, 32'h0, 32'h0BADF00D, 0);
      mtxn(1, 1'b0, 32'h13, 32'h0, 0);
      mtxn(1, 1'b1, 32'h4000, 32'hFFFFFFFF, 0);
      mtxn(1, 1'b0, 32'h0, 32'h0, 0);

      // Back-to-back reads with no wait states and req held through the bubble.
      mtxn(0, 1'b1, 32'h0, 32'hA5A50001, 0);
      mtxn(0, 1'b1, 32'h4, 32'h5A5A0002, 0);
      @(posedge clk); #1;
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
      first = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rv[k]  = ready[0];
         rdv[k] = rdata[0];
         if (ready[0]) begin
            if (!first) begin
               first = 1;
               addr[0] = 32'h4;
            end else begin
               req[0] = 1'b0;
            end
         end
      end
      check_eq("b2b ready c0", 32'(rv[0]), 32'd0);
      check_eq("b2b ready c1", 32'(rv[1]), 32'd1);
      check_eq("b2b rdata c1", rdv[1], 32'hA5A50001);
      check_eq("b2b ready c2", 32'(rv[2]), 32'd0);
      check_eq("b2b ready c3", 32'(rv[3]), 32'd1);
      check_eq("b2b rdata c3", rdv[3], 32'h5A5A0002);
      check_eq("b2b ready c4", 32'(rv[4]), 32'd0);

      // Store aborted by dropping req in the first wait cycle.
      mtxn(1, 1'b1, 32'h20, 32'h55AA55AA, 0);
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h1234;
      @(negedge clk);
      @(negedge clk);
      req[1] = 1'b0;
      hits = 0;
      repeat (6) begin
         @(negedge clk);
         if (ready[1]) hits++;
      end
      check_eq("abort ready count", 32'(hits), 32'd0);
      mtxn(1, 1'b0, 32'h20, 32'h0, 0);

      // Reset during the wait of a store.
      mtxn(1, 1'b1, 32'h24, 32'h11112222, 0);
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h24; wdata[1] = 32'h99;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rst wait ready", 32'(ready[1]), 32'd0);
      check_eq("rst wait err", 32'(err[1]), 32'd0);
      req[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mtxn(1, 1'b0, 32'h24, 32'h0, 0);

      // Reset during the response cycle of a store: ready clears at once, no write.
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h24; wdata[1] = 32'h77;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (ready[1]) seen = 1;
      end
      check_eq("rst resp reached", 32'(seen), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rst resp ready", 32'(ready[1]), 32'd0);
      req[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mtxn(1, 1'b0, 32'h24, 32'h0, 0);

      // Inputs disturbed after acceptance.
      mtxn(1, 1'b1, 32'h2C, 32'h31415926, 0);
      mtxn(1, 1'b1, 32'h28, 32'hCAFEF00D, 1);
      mtxn(1, 1'b0, 32'h28, 32'h0, 0);
      mtxn(1, 1'b0, 32'h2C, 32'h0, 0);

      // Randomized traffic over a small word pool plus faulting addresses.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 16; i++) mtxn(s, 1'b1, 32'(i * 4), $urandom, 0);
      end
      for (int n = 0; n < 120; n++) begin
         int          sel;
         int          choice;
         logic        w;
         logic [31:0] a;
         bit          tog;
         sel    = int'($urandom_range(0, 1));
         w      = 1'($urandom_range(0, 1));
         choice = int'($urandom_range(0, 9));
         a      = 32'($urandom_range(0, 15)) * 4;
         if (choice == 7)      a = a + 32'($urandom_range(1, 3));
         else if (choice == 8) a = a + 32'h1000;
         else if (choice == 9) a = ($urandom | 32'h0000_1000) & ~32'h3;
         tog = ($urandom_range(0, 3) == 0);
         mtxn(sel, w, a, $urandom, tog);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
